vec_regfile_rd_stage: RTL and testbench
=======================================

// Module: vec_regfile_rd_stage
// PURPOSE
//   16-entry x 128-bit vector register file with registered dual read, the decode->execute stage.
//   Feeds the forwarding unit's inputs: R2/R3 operand values plus the aligned source register numbers.
//   The single write port is driven by writeback and supports byte-lane masks for alpha-compositing ops.
//   Same-cycle write->read bypass; the forwarding unit only handles the in-flight results.
// PARAMETERS
//   DATA_W  128  vector register width (bits)
//   ADDR_W  4    register index width; 2**ADDR_W entries; V0 hardwired to zero
//   LANE_W  8    byte-lane width; DATA_W/LANE_W lanes (16 by default)
// PORTS
//   clk        in   1                clock, rising edge
//   rst        in   1                asynchronous reset, active low
//   in_valid   in   1                decode slot holds a real instruction
//   stall      in   1                hold the stage: addresses/valid frozen
//   flush      in   1                squash the stage (priority over stall)
//   rd_addr2   in   ADDR_W           source register R2 index
//   rd_addr3   in   ADDR_W           source register R3 index
//   wr_en      in   1                writeback write enable
//   wr_addr    in   ADDR_W           writeback destination register
//   wr_mask    in   DATA_W/LANE_W    per-lane write enable, bit i -> bits [i*LANE_W +: LANE_W]
//   wr_data    in   DATA_W           writeback data
//   out_valid  out  1                registered valid to execute
//   R2_q       out  ADDR_W           registered R2 index (to forward unit)
//   R3_q       out  ADDR_W           registered R3 index (to forward unit)
//   R2res_q    out  DATA_W           registered R2 operand value
//   R3res_q    out  DATA_W           registered R3 operand value
// BEHAVIOUR
//   Reset (rst=0, async, any time): all entries, out_valid, R2_q, R3_q, R2res_q, R3res_q -> 0.
//     Deassertion is sampled at clk. Mid-operation reset discards pending writes and reads.
//   Write, at posedge when wr_en=1 and wr_addr!=0:
//     for every lane i with wr_mask[i]=1, entry[wr_addr] lane i <= wr_data lane i; other lanes keep value.
//     A write to V0 is ignored. wr_en=1 with wr_mask=0 leaves the array unchanged.
//   Bypassed read value rv(a), combinational:
//     a==0 -> 0.
//     Else if wr_en and wr_addr==a -> masked lanes from wr_data, unmasked lanes from entry[a].
//     Else -> entry[a].
//   Stage register update at posedge, priority flush > stall > normal:
//     flush:  out_valid<=0, R2_q<=0, R3_q<=0, R2res_q<=0, R3res_q<=0. A concurrent write still commits.
//     stall:  out_valid, R2_q, R3_q hold.
//             R2res_q<=rv(R2_q), R3res_q<=rv(R3_q): data is refreshed so a writeback during a stall
//             is never lost (no stale operand).
//     normal: out_valid<=in_valid, R2_q<=rd_addr2, R3_q<=rd_addr3,
//             R2res_q<=rv(rd_addr2), R3res_q<=rv(rd_addr3).
//   Latency: 1 cycle from address to operand. A value written in cycle N is visible to a read issued in cycle N.
//   Reads do not depend on in_valid (data captured regardless); execute qualifies with out_valid.
//   rd_addr2==rd_addr3: both outputs carry the same value. No read-port conflicts exist.
//   DATA_W must be a multiple of LANE_W (elaboration-time check).
// TESTING
//   1. Reset then read V1,V2 -> R2res_q=0, R3res_q=0, out_valid=0 until in_valid is captured.
//   2. Write V5=128'h15 (mask 16'hFFFF); next cycle read R2=5,R3=6 -> R2res_q=128'h15, R3res_q=0, R2_q=5, R3_q=6.
//   3. Same-cycle bypass: V6=128'h64; write V6=128'hAABB with mask 16'h0001 while reading R3=6
//      -> R3res_q=128'h64 with byte0=8'hBB, i.e. 128'h..00BB in lane 0, upper lanes unchanged (128'h00BB? lane1=8'h00).
//   4. Write V0=128'hFF..FF, then read R2=0 -> R2res_q=0.
//   5. Stall for 3 cycles with R2_q=5 while V5 is written 128'h99 in stall cycle 2
//      -> R2_q holds 5, R2res_q=128'h99 from the following edge.
//   6. flush and stall together with in_valid=1 -> out_valid=0, all outputs 0; assert rst mid-stall -> immediate clear.

Source files
------------

// File: rtl/vec_regfile_rd_stage.sv
// Vector register file (V0 hardwired to zero) with byte-lane masked writeback and a registered
// dual-read decode->execute stage. Same-cycle write data is bypassed into the operand read.
module vec_regfile_rd_stage #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4,
    parameter int LANE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        rd_addr2,
    input  logic [ADDR_W-1:0]        rd_addr3,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/LANE_W-1:0] wr_mask,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        R2_q,
    output logic [ADDR_W-1:0]        R3_q,
    output logic [DATA_W-1:0]        R2res_q,
    output logic [DATA_W-1:0]        R3res_q
);

    localparam int LANES    = DATA_W / LANE_W;
    localparam int NUM_REGS = 2 ** ADDR_W;

    if (DATA_W % LANE_W != 0) begin : g_lane_check
        $error("DATA_W must be a multiple of LANE_W");
    end

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_valid;
    logic [ADDR_W-1:0] r_r2_q;
    logic [ADDR_W-1:0] r_r3_q;
    logic [DATA_W-1:0] r_r2_res;
    logic [DATA_W-1:0] r_r3_res;

    logic [DATA_W-1:0] w_bitmask;
    logic [DATA_W-1:0] w_wr_merged;
    logic [ADDR_W-1:0] w_sel2;
    logic [ADDR_W-1:0] w_sel3;
    logic [DATA_W-1:0] w_rv2;
    logic [DATA_W-1:0] w_rv3;

    always_comb begin
        w_bitmask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_bitmask[i*LANE_W +: LANE_W] = {LANE_W{wr_mask[i]}};
        end
    end

    // The merged word serves both the array update and the same-cycle bypass.
    assign w_wr_merged = (r_regs[wr_addr] & ~w_bitmask) | (wr_data & w_bitmask);

    // During a stall the held addresses are re-read so a writeback landing mid-stall is picked up.
    assign w_sel2 = stall ? r_r2_q : rd_addr2;
    assign w_sel3 = stall ? r_r3_q : rd_addr3;

    assign w_rv2 = (w_sel2 == '0) ? '0 :
                   (wr_en && wr_addr == w_sel2) ? w_wr_merged : r_regs[w_sel2];
    assign w_rv3 = (w_sel3 == '0) ? '0 :
                   (wr_en && wr_addr == w_sel3) ? w_wr_merged : r_regs[w_sel3];

    // NOTE: the array is reset as flops (not a RAM macro) because reset must clear every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            r_regs[wr_addr] <= w_wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_r2_q   <= '0;
            r_r3_q   <= '0;
            r_r2_res <= '0;
            r_r3_res <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_r2_q   <= '0;
            r_r3_q   <= '0;
            r_r2_res <= '0;
            r_r3_res <= '0;
        end else if (stall) begin
            r_r2_res <= w_rv2;
            r_r3_res <= w_rv3;
        end else begin
            r_valid  <= in_valid;
            r_r2_q   <= rd_addr2;
            r_r3_q   <= rd_addr3;
            r_r2_res <= w_rv2;
            r_r3_res <= w_rv3;
        end
    end

    assign out_valid = r_valid;
    assign R2_q      = r_r2_q;
    assign R3_q      = r_r3_q;
    assign R2res_q   = r_r2_res;
    assign R3res_q   = r_r3_res;

endmodule

// File: tb/tb_vec_regfile_rd_stage.sv
// Randomized bench for vec_regfile_rd_stage: a lane-level behavioural model predicts every
// stage output after each clock edge; directed sequences cover reset, bypass, V0, stall and flush.
module tb_vec_regfile_rd_stage;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 4;
    localparam int LANE_W = 8;
    localparam int LANES  = DATA_W / LANE_W;
    localparam int NREGS  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, stall, flush, wr_en;
    logic [ADDR_W-1:0] rd_addr2, rd_addr3, wr_addr;
    logic [LANES-1:0]  wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic [ADDR_W-1:0] R2_q, R3_q;
    logic [DATA_W-1:0] R2res_q, R3res_q;

    // Behavioural model state
    logic [DATA_W-1:0] m_regs [NREGS];
    logic              m_valid;
    int                m_r2, m_r3;
    logic [DATA_W-1:0] m_res2, m_res3;

    int n_checks = 0;
    int n_pass   = 0;

    vec_regfile_rd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .out_valid(out_valid), .R2_q(R2_q),
        .R3_q(R3_q), .R2res_q(R2res_q), .R3res_q(R3res_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_r2 = 0;
        m_r3 = 0;
        m_res2 = '0;
        m_res3 = '0;
    endtask

    // Operand value seen by a read of register a this cycle, including the in-flight write.
    function automatic logic [DATA_W-1:0] m_read(input int a);
        logic [DATA_W-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        if (wr_en && int'(wr_addr) == a) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) v[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
            end
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(m_valid));
        check({tag, ".R2_q"},  DATA_W'(R2_q),      DATA_W'(m_r2));
        check({tag, ".R3_q"},  DATA_W'(R3_q),      DATA_W'(m_r3));
        check({tag, ".R2res"}, R2res_q,            m_res2);
        check({tag, ".R3res"}, R3res_q,            m_res3);
    endtask

    // One clock: model follows the edge using the stable inputs, then outputs are compared.
    task automatic step(input string tag);
        logic [DATA_W-1:0] n2, n3;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0; m_r2 = 0; m_r3 = 0; m_res2 = '0; m_res3 = '0;
        end else if (stall) begin
            n2 = m_read(m_r2);
            n3 = m_read(m_r3);
            m_res2 = n2;
            m_res3 = n3;
        end else begin
            n2 = m_read(int'(rd_addr2));
            n3 = m_read(int'(rd_addr3));
            m_valid = in_valid;
            m_r2 = int'(rd_addr2);
            m_r3 = int'(rd_addr3);
            m_res2 = n2;
            m_res3 = n3;
        end
        if (wr_en && wr_addr != 0) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) m_regs[wr_addr][l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic iv, input logic st, input logic fl,
                         input int a2, input int a3, input logic we, input int wa,
                         input logic [LANES-1:0] wm, input logic [DATA_W-1:0] wd);
        in_valid = iv; stall = st; flush = fl;
        rd_addr2 = ADDR_W'(a2); rd_addr3 = ADDR_W'(a3);
        wr_en = we; wr_addr = ADDR_W'(wa); wr_mask = wm; wr_data = wd;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: read V1,V2 after reset, valid low until captured
        drive(0, 0, 0, 1, 2, 0, 0, '0, '0);
        step("t1_noval");
        drive(1, 0, 0, 1, 2, 0, 0, '0, '0);
        step("t1_val");

        // 2: write V5 then read R2=5, R3=6
        drive(1, 0, 0, 1, 2, 1, 5, 16'hFFFF, 128'h15);
        step("t2_wr");
        drive(1, 0, 0, 5, 6, 0, 0, '0, '0);
        step("t2_rd");
        check("t2_R2res_const", R2res_q, 128'h15);

        // 3: same-cycle lane-0 bypass into V6
        drive(1, 0, 0, 0, 0, 1, 6, 16'hFFFF, 128'h64);
        step("t3_init");
        drive(1, 0, 0, 5, 6, 1, 6, 16'h0001, 128'hAABB);
        step("t3_bypass");
        check("t3_R3res_const", R3res_q, 128'hBB);

        // 4: V0 ignores writes, including a same-cycle read of V0
        drive(1, 0, 0, 0, 0, 1, 0, 16'hFFFF, {DATA_W{1'b1}});
        step("t4_wr_v0");
        drive(1, 0, 0, 0, 0, 0, 0, '0, '0);
        step("t4_rd_v0");

        // empty mask leaves the entry alone
        drive(1, 0, 0, 5, 5, 1, 5, '0, {DATA_W{1'b1}});
        step("mask0_wr");
        drive(1, 0, 0, 5, 5, 0, 0, '0, '0);
        step("mask0_rd");

        // 5: stall 3 cycles with R2_q=5; V5 written in stall cycle 2
        drive(1, 0, 0, 5, 6, 0, 0, '0, '0);
        step("t5_cap");
        drive(0, 1, 0, 7, 8, 0, 0, '0, '0);
        step("t5_st1");
        drive(0, 1, 0, 7, 8, 1, 5, 16'hFFFF, 128'h99);
        step("t5_st2");
        check("t5_R2res_const", R2res_q, 128'h99);
        drive(0, 1, 0, 7, 8, 0, 0, '0, '0);
        step("t5_st3");
        check("t5_R2_q_const", DATA_W'(R2_q), DATA_W'(5));

        // 6: flush wins over stall; concurrent write still commits
        drive(1, 1, 1, 5, 6, 1, 9, 16'h00FF, rand_data());
        step("t6_flush");
        drive(1, 0, 0, 9, 5, 0, 0, '0, '0);
        step("t6_rd9");
        drive(0, 1, 0, 3, 4, 0, 0, '0, '0);
        step("t6_stall");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_async_rst");
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 9, 5, 0, 0, '0, '0);
        step("t6_after_rst");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [LANES-1:0] m;
            case ($urandom_range(0, 3))
                0:       m = '1;
                1:       m = '0;
                default: m = LANES'($urandom);
            endcase
            drive(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)),
                  ($urandom_range(0, 4) < 3), int'($urandom_range(0, NREGS-1)), m, rand_data());
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
